// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM access sequencer.
// Holds the bus widths (matching sdram_address_calc and the Avalon-MM
// controller), the default read timeout and the sequencer state type.
package sdram_pkg;

    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ISSUE   = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } sac_state_t;

endpackage

// File: rtl/sdram_access_ctrl_if.sv
// Bundle of the sequencer's request, address-calculator and Avalon-MM signals.
//   request side : rd_req, wr_req, wr_data -> req_ack, rd_data, rd_valid,
//                  done, timeout_err
//   calculator   : calc_mode, calc_enable -> ; sdram_address <-
//   Avalon-MM    : avm_address, avm_read, avm_write, avm_writedata ->
//                  ; avm_waitrequest, avm_readdata, avm_readdatavalid <-
// slave  : the sequencer's view
// master : the view of everything surrounding the sequencer
interface sdram_access_ctrl_if #(
    parameter int ADDR_W = sdram_pkg::ADDR_W,
    parameter int DATA_W = sdram_pkg::DATA_W
);
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              req_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              timeout_err;
    logic              calc_mode;
    logic              calc_enable;
    logic [ADDR_W-1:0] sdram_address;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport slave (
        input  rd_req, wr_req, wr_data, sdram_address,
               avm_waitrequest, avm_readdata, avm_readdatavalid,
        output req_ack, rd_data, rd_valid, done, timeout_err,
               calc_mode, calc_enable,
               avm_address, avm_read, avm_write, avm_writedata
    );

    modport master (
        output rd_req, wr_req, wr_data, sdram_address,
               avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  req_ack, rd_data, rd_valid, done, timeout_err,
               calc_mode, calc_enable,
               avm_address, avm_read, avm_write, avm_writedata
    );
endinterface

// File: rtl/sdram_access_ctrl.sv
// Single-word SDRAM transaction sequencer.
// Accepts one read or write request at a time, steers sdram_address_calc
// (mode/enable), issues the command on Avalon-MM and returns read data.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    sdram_access_ctrl_if.slave (request, calculator, Avalon signals)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for rd_req/wr_req; write wins a tie
// SETUP   | one cycle for sdram_address to follow the new calc_mode
// ISSUE   | avm_read/avm_write held until waitrequest drops
// RD_WAIT | waiting for readdatavalid, bounded by TIMEOUT
// DONE    | one-cycle done pulse
module sdram_access_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic n_rst,
    sdram_access_ctrl_if.slave bus
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    sac_state_t        state_q, state_d;
    logic              is_rd_q, is_rd_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              terr_q, terr_d;

    logic req_ack, calc_enable, avm_read, avm_write, done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            is_rd_q  <= 1'b0;
            mode_q   <= 1'b1;
            wdata_q  <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_rd_q  <= is_rd_d;
            mode_q   <= mode_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_rd_d     = is_rd_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        cnt_d       = '0;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        terr_d      = terr_q;
        req_ack     = 1'b0;
        calc_enable = 1'b0;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    req_ack = 1'b1;
                    is_rd_d = !bus.wr_req;
                    mode_d  = !bus.wr_req;
                    if (bus.wr_req) begin
                        wdata_d = bus.wr_data;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                addr_d  = bus.sdram_address;
                state_d = ISSUE;
            end
            ISSUE: begin
                avm_read  = is_rd_q;
                avm_write = !is_rd_q;
                if (!bus.avm_waitrequest) begin
                    // Pointer advances only once the controller has the command.
                    calc_enable = 1'b1;
                    state_d     = is_rd_q ? RD_WAIT : DONE;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving in the terminal-count cycle still wins.
                if (bus.avm_readdatavalid) begin
                    rdata_d  = bus.avm_readdata;
                    rvalid_d = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == TO_CNT) begin
                    terr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ack       = req_ack;
    assign bus.calc_enable   = calc_enable;
    assign bus.avm_read      = avm_read;
    assign bus.avm_write     = avm_write;
    assign bus.done          = done;
    assign bus.calc_mode     = mode_q;
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = wdata_q;
    assign bus.rd_data       = rdata_q;
    assign bus.rd_valid      = rvalid_q;
    assign bus.timeout_err   = terr_q;

endmodule

// File: tb/tb_sdram_access_ctrl.sv
module tb_sdram_access_ctrl;

    localparam int TO     = 255;
    localparam int START  = 300;
    localparam int FINISH = 3000;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sdram_access_ctrl_if ifc ();

    sdram_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifc.slave)
    );

    // Stand-in for sdram_address_calc: reads walk up from START, writes from FINISH.
    logic [25:0] c_rd_ptr, c_wr_ptr;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c_rd_ptr <= 26'(START);
            c_wr_ptr <= 26'(FINISH);
        end else if (ifc.calc_enable) begin
            if (ifc.calc_mode) c_rd_ptr <= c_rd_ptr + 26'd1;
            else               c_wr_ptr <= c_wr_ptr + 26'd1;
        end
    end
    assign ifc.sdram_address = ifc.calc_mode ? c_rd_ptr : c_wr_ptr;

    function automatic logic [31:0] mem_word(input logic [25:0] a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Avalon slave knobs and event log
    int   cyc = 0;
    int   slave_wait = 0;
    int   slave_lat = 0;
    bit   noise_en = 0;
    bit   rv_pend = 0;
    int   rv_cyc = 0;
    logic [31:0] rv_data = '0;
    bit   prev_cmd = 0;

    int   n_ack, ack_cyc, n_cal, cal_cyc, calc_total = 0;
    int   n_cmd, cmd_start, cmd_len, stab_err;
    logic [25:0] cmd_addr;
    logic [31:0] cmd_wdata;
    bit   cmd_wr;
    int   n_rv, rvd_cyc, n_done, done_cyc;
    logic [31:0] rvd_data;

    task automatic clr_log();
        n_ack = 0; n_cal = 0; n_cmd = 0; cmd_len = 0; stab_err = 0;
        n_rv = 0; n_done = 0;
        ack_cyc = -1; cal_cyc = -1; cmd_start = -1; rvd_cyc = -1; done_cyc = -1;
        cmd_addr = '0; cmd_wdata = '0; cmd_wr = 0; rvd_data = '0;
    endtask

    initial begin
        ifc.avm_waitrequest   = 1'b0;
        ifc.avm_readdatavalid = 1'b0;
        ifc.avm_readdata      = '0;
    end

    // Slave drives at the falling edge, log samples 1 time unit later.
    always begin
        bit cmd;
        @(negedge clk);
        cyc++;
        cmd = ifc.avm_read || ifc.avm_write;
        ifc.avm_waitrequest = cmd && ((prev_cmd ? cmd_len : 0) < slave_wait);
        if (rv_pend && cyc == rv_cyc) begin
            ifc.avm_readdatavalid = 1'b1;
            ifc.avm_readdata      = rv_data;
            rv_pend               = 0;
        end else begin
            ifc.avm_readdatavalid = noise_en && ($urandom_range(0, 3) == 0);
            ifc.avm_readdata      = $urandom;
        end
        #1;
        if (ifc.req_ack) begin n_ack++; ack_cyc = cyc; end
        if (ifc.calc_enable) begin n_cal++; cal_cyc = cyc; calc_total++; end
        cmd = ifc.avm_read || ifc.avm_write;
        if (cmd) begin
            if (!prev_cmd) begin
                n_cmd++;
                cmd_start = cyc;
                cmd_addr  = ifc.avm_address;
                cmd_wr    = ifc.avm_write;
                cmd_wdata = ifc.avm_writedata;
                cmd_len   = 0;
            end else if (ifc.avm_address != cmd_addr || ifc.avm_write != cmd_wr ||
                         ifc.avm_read == cmd_wr || ifc.avm_writedata != cmd_wdata) begin
                stab_err++;
            end
            cmd_len++;
            if (!ifc.avm_waitrequest && ifc.avm_read && slave_lat > 0) begin
                rv_pend = 1;
                rv_cyc  = cyc + slave_lat;
                rv_data = mem_word(ifc.avm_address);
            end
        end
        prev_cmd = cmd;
        if (ifc.rd_valid) begin n_rv++; rvd_cyc = cyc; rvd_data = ifc.rd_data; end
        if (ifc.done) begin n_done++; done_cyc = cyc; end
    end

    // Transaction-level reference state
    logic [25:0] m_rd = 26'(START);
    logic [25:0] m_wr = 26'(FINISH);
    bit          exp_terr = 0;

    // lat = 0 means the slave never returns data.
    task automatic run_txn(input bit wr, input bit both, input logic [31:0] wd,
                           input int wt, input int lat);
        int          t, acc, exp_done, budget;
        bit          rd_ok;
        logic [25:0] ea;
        slave_wait = wt;
        slave_lat  = lat;
        noise_en   = 0;
        clr_log();
        ifc.wr_req  = wr;
        ifc.rd_req  = !wr || both;
        ifc.wr_data = wd;
        t = cyc + 1;
        @(posedge clk); #1;
        ifc.wr_data = $urandom;
        // A request while busy must be ignored.
        ifc.wr_req  = 1'($urandom_range(0, 1));
        ifc.rd_req  = !ifc.wr_req;
        @(posedge clk); #1;
        ifc.wr_req = 0;
        ifc.rd_req = 0;
        budget = 0;
        while (n_done == 0 && budget < 400) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("done_seen", 32'(n_done > 0), 32'd1);
        repeat (2) begin @(posedge clk); #1; end

        ea       = wr ? m_wr : m_rd;
        acc      = t + 2 + wt;
        rd_ok    = !wr && lat >= 1 && lat <= TO + 1;
        exp_done = wr ? acc + 1 : (rd_ok ? acc + lat + 1 : acc + TO + 2);
        if (!wr && !rd_ok) exp_terr = 1;

        chk("n_ack", n_ack, 1);
        chk("ack_cyc", ack_cyc, t);
        chk("n_cmd", n_cmd, 1);
        chk("cmd_start", cmd_start, t + 2);
        chk("cmd_addr", 32'(cmd_addr), 32'(ea));
        chk("cmd_dir", 32'(cmd_wr), 32'(wr));
        chk("cmd_len", cmd_len, wt + 1);
        chk("cmd_stable", stab_err, 0);
        if (wr) chk("cmd_wdata", cmd_wdata, wd);
        chk("n_calc", n_cal, 1);
        chk("calc_cyc", cal_cyc, acc);
        chk("n_done", n_done, 1);
        chk("done_cyc", done_cyc, exp_done);
        chk("n_rdv", n_rv, 32'(rd_ok));
        if (rd_ok) begin
            chk("rdv_cyc", rvd_cyc, acc + lat + 1);
            chk("rd_data", rvd_data, mem_word(ea));
        end
        chk("timeout_err", 32'(ifc.timeout_err), 32'(exp_terr));
        chk("calc_mode", 32'(ifc.calc_mode), 32'(!wr));
        if (wr) m_wr = m_wr + 26'd1;
        else    m_rd = m_rd + 26'd1;
    endtask

    task automatic gap(input int n);
        clr_log();
        noise_en = 1;
        repeat (n) begin @(posedge clk); #1; end
        noise_en = 0;
        chk("gap_quiet", n_rv + n_done + n_ack + n_cal, 0);
    endtask

    initial begin
        int t, cal0;
        n_rst      = 1'b0;
        ifc.rd_req = 1'b0;
        ifc.wr_req = 1'b0;
        ifc.wr_data = '0;
        clr_log();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_calc_mode", 32'(ifc.calc_mode), 32'd1);
        chk("rst_avm_read", 32'(ifc.avm_read), 32'd0);
        chk("rst_avm_write", 32'(ifc.avm_write), 32'd0);
        chk("rst_outs", 32'({ifc.req_ack, ifc.rd_valid, ifc.done, ifc.timeout_err, ifc.calc_enable}), 32'd0);
        chk("rst_avm_addr", 32'(ifc.avm_address), 32'd0);
        chk("rst_rd_data", ifc.rd_data, 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        gap(2);

        // Basic reads and writes
        run_txn(0, 0, 32'h0, 0, 2);
        run_txn(0, 0, 32'h0, 0, 2);
        run_txn(1, 0, 32'hDEADBEEF, 3, 1);
        run_txn(1, 0, $urandom, 0, 1);
        // Simultaneous requests: write wins, read is dropped
        run_txn(1, 1, $urandom, 1, 1);
        run_txn(0, 0, 32'h0, 0, 3);
        gap(3);

        // Timeout and its boundary
        run_txn(0, 0, 32'h0, 0, 0);
        run_txn(0, 0, 32'h0, 1, 4);
        run_txn(0, 0, 32'h0, 0, TO + 1);
        run_txn(0, 0, 32'h0, 0, TO + 2);

        // Reset while a read is stalled in the issue phase
        slave_wait = 1000;
        slave_lat  = 1;
        clr_log();
        ifc.rd_req = 1;
        t = cyc + 1;
        @(posedge clk); #1;
        ifc.rd_req = 0;
        @(posedge clk); #1;
        @(negedge clk); #2;
        chk("pre_rst_read", 32'(ifc.avm_read), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_read", 32'(ifc.avm_read), 32'd0);
        chk("mid_rst_mode", 32'(ifc.calc_mode), 32'd1);
        chk("mid_rst_terr", 32'(ifc.timeout_err), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        n_rst = 1'b1;
        chk("mid_rst_ncal", n_cal, 0);
        chk("mid_rst_ncmd", n_cmd, 1);
        m_rd = 26'(START);
        m_wr = 26'(FINISH);
        exp_terr = 0;
        gap(2);
        run_txn(0, 0, 32'h0, 0, 2);

        // Alternating reads and writes with random stalls and latencies
        cal0 = calc_total;
        for (int i = 0; i < 10; i++) begin
            run_txn(0, 0, 32'h0, $urandom_range(0, 3), $urandom_range(1, 6));
            gap($urandom_range(1, 3));
            run_txn(1, 0, $urandom, $urandom_range(0, 3), 1);
            gap($urandom_range(1, 3));
        end
        chk("calc_total", calc_total - cal0, 20);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom,
                    $urandom_range(0, 4), $urandom_range(1, 12));
            gap($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
